// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and framebuffer word-address helper for the
// framebuffer memory arbiter.
package fb_pkg;

    localparam int FB_WORDS       = 9600;
    localparam int LINE_WORDS     = 40;
    localparam int LINES          = 240;
    localparam int CPU_SLOT_EVERY = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // line*40 is built from two shifts so no multiplier is inferred.
    function automatic logic [14:0] fb_word_addr(input logic       buf_sel,
                                                 input logic [7:0] line,
                                                 input logic [5:0] idx);
        logic [14:0] base;
        logic [14:0] l;
        base = buf_sel ? 15'(FB_WORDS) : 15'd0;
        l    = {7'd0, line};
        return base + (l << 5) + (l << 3) + {9'd0, idx};
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational address mapper: video (buffer, line, idx) and CPU (buffer, offset)
// to 15-bit BRAM word addresses, with a range check on the CPU offset.
module fb_addr_gen
    import fb_pkg::*;
(
    input  logic        vid_buf,
    input  logic [7:0]  vid_line,
    input  logic [5:0]  vid_idx,
    input  logic        cpu_buf,
    input  logic [13:0] cpu_offset,
    output logic [14:0] vid_word,
    output logic [14:0] cpu_word,
    output logic        cpu_hit
);

    assign vid_word = fb_word_addr(vid_buf, vid_line, vid_idx);
    assign cpu_hit  = cpu_offset < 14'(FB_WORDS);
    assign cpu_word = (cpu_buf ? 15'(FB_WORDS) : 15'd0) + {1'b0, cpu_offset};

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer scheduler: video line prefetch has priority, the CPU
// gets a guaranteed slot every CPU_SLOT_EVERY video cycles; front/back swap at frame start.
module fb_mem_arbiter
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        cpu_valid,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        vid_frame_start,
    input  logic        vid_line_start,
    input  logic [7:0]  vid_line,
    output logic        vid_valid,
    output logic [5:0]  vid_idx,
    output logic [31:0] vid_data,
    output logic        vid_restart,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        front_sel,
    output state_t      dbg_state
);

    state_t      state_q, state_n;
    logic [7:0]  line_q, line_n;
    logic [5:0]  idx_q, idx_n;
    logic        fbuf_q, fbuf_n;
    logic [3:0]  slot_q, slot_n;
    logic        restart_n;
    logic        cpu_free, cpu_mem, cpu_skip, vid_issue, swap_hit;
    logic [14:0] vid_word, cpu_word;
    logic        cpu_hit;

    fb_addr_gen u_addr_gen (
        .vid_buf    (fbuf_q),
        .vid_line   (line_q),
        .vid_idx    (idx_q),
        .cpu_buf    (~front_sel),
        .cpu_offset (cpu_addr),
        .vid_word   (vid_word),
        .cpu_word   (cpu_word),
        .cpu_hit    (cpu_hit)
    );

    // CPU handshake: a request is taken in a cycle where cpu_valid is high and
    // cpu_ready is low; cpu_ready pulses the following cycle and the requester
    // must drop or replace the request then. Out-of-range requests are acked
    // without touching the memory port, so video keeps its cycle.
    always_comb begin
        cpu_free  = cpu_valid && !cpu_ready && !reset;
        cpu_mem   = cpu_free && cpu_hit &&
                    (state_q == IDLE || slot_q == 4'(CPU_SLOT_EVERY));
        cpu_skip  = cpu_free && !cpu_hit;
        vid_issue = (state_q == FETCH) && !cpu_mem && !reset;
        swap_hit  = vid_frame_start && (swap_pending || swap_req);

        mem_addr  = 15'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (cpu_mem) begin
            mem_addr  = cpu_word;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end else if (vid_issue) begin
            mem_addr  = vid_word;
        end
    end

    always_comb begin
        state_n   = state_q;
        line_n    = line_q;
        idx_n     = idx_q;
        fbuf_n    = fbuf_q;
        slot_n    = slot_q;
        restart_n = 1'b0;
        if (vid_issue) begin
            if (slot_q != 4'(CPU_SLOT_EVERY)) slot_n = slot_q + 4'd1;
            if (idx_q == 6'(LINE_WORDS - 1)) begin
                state_n = IDLE;
                idx_n   = 6'd0;
            end else begin
                idx_n   = idx_q + 6'd1;
            end
        end
        if (cpu_mem) slot_n = 4'd0;
        // The buffer is latched here so a swap mid-line cannot tear the line.
        if (vid_line_start && vid_line < 8'(LINES)) begin
            state_n   = FETCH;
            line_n    = vid_line;
            idx_n     = 6'd0;
            fbuf_n    = front_sel;
            restart_n = (state_q == FETCH);
        end
        if (state_n == IDLE) slot_n = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            line_q       <= 8'd0;
            idx_q        <= 6'd0;
            fbuf_q       <= 1'b0;
            slot_q       <= 4'd0;
            vid_valid    <= 1'b0;
            vid_idx      <= 6'd0;
            vid_data     <= 32'd0;
            vid_restart  <= 1'b0;
            cpu_ready    <= 1'b0;
            cpu_rdata    <= 32'd0;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
        end else begin
            state_q      <= state_n;
            line_q       <= line_n;
            idx_q        <= idx_n;
            fbuf_q       <= fbuf_n;
            slot_q       <= slot_n;
            vid_restart  <= restart_n;
            vid_valid    <= vid_issue;
            vid_idx      <= vid_issue ? idx_q : 6'd0;
            vid_data     <= vid_issue ? mem_rdata : 32'd0;
            cpu_ready    <= cpu_mem || cpu_skip;
            cpu_rdata    <= (cpu_mem && cpu_wstrb == 4'd0) ? mem_rdata : 32'd0;
            if (swap_hit) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: BRAM model, driver tasks, video scoreboard
// with expected queue, and a one-line final report.
module tb_fb_mem_arbiter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        cpu_valid;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        vid_frame_start;
  logic        vid_line_start;
  logic [7:0]  vid_line;
  logic        vid_valid;
  logic [5:0]  vid_idx;
  logic [31:0] vid_data;
  logic        vid_restart;
  logic        swap_req;
  logic        swap_pending;
  logic        front_sel;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] exp_q[$];
  logic [31:0] mem [0:19199];

  fb_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .vid_frame_start(vid_frame_start), .vid_line_start(vid_line_start), .vid_line(vid_line),
    .vid_valid(vid_valid), .vid_idx(vid_idx), .vid_data(vid_data), .vid_restart(vid_restart),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 15'd19200) ? mem[mem_addr] : 32'hDEAD0000;

  always @(posedge clk) begin
    if (mem_wstrb != 4'd0 && mem_addr < 15'd19200) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 ^ 32'(a);
  endfunction

  // Expected memory contents after the writes this bench issues
  function automatic logic [31:0] exp_word(input int a);
    if (a < 9600) return pat(a);
    if (a == 9605) return 32'h0000_BEEF;
    if (a == 9700) return 32'h1234_5678;
    return 32'd0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && vid_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("vid_extra", {26'd0, vid_idx}, 32'hFFFF_FFFF);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check("vid_idx", {26'd0, vid_idx}, {26'd0, e[37:32]});
        check("vid_data", vid_data, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_line(input int line, input int bsel, input int last_idx);
    for (int i = 0; i <= last_idx; i++)
      exp_q.push_back({6'(i), exp_word(bsel * 9600 + line * 40 + i)});
  endtask

  // Full uninterrupted line fetch; issue cycles follow the start pulse back to back.
  task automatic run_line(input int line, input int bsel);
    cyc();
    vid_line_start = 1'b1;
    vid_line = 8'(line);
    push_line(line, bsel, 39);
    smp();
    for (int i = 0; i < 40; i++) begin
      cyc();
      vid_line_start = 1'b0;
      smp();
      check("fetch_addr", {17'd0, mem_addr}, 32'(bsel * 9600 + line * 40 + i));
      check("fetch_wstrb", {28'd0, mem_wstrb}, 32'd0);
    end
    cyc();
    smp();
    check("last_valid", {31'd0, vid_valid}, 32'd1);
    check("last_state", {31'd0, dbg_state}, {31'd0, IDLE});
    cyc();
    smp();
    check("valid_off", {31'd0, vid_valid}, 32'd0);
  endtask

  task automatic cpu_idle(input int addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int exp_addr, input logic [31:0] exp_rd);
    cyc();
    cpu_valid = 1'b1;
    cpu_addr = 14'(addr);
    cpu_wdata = wd;
    cpu_wstrb = ws;
    smp();
    check("cpu_mem_addr", {17'd0, mem_addr}, 32'(exp_addr));
    check("cpu_mem_wstrb", {28'd0, mem_wstrb}, (exp_addr == 0 && addr >= 9600) ? 32'd0 : {28'd0, ws});
    cyc();
    cpu_valid = 1'b0;
    smp();
    check("cpu_ready", {31'd0, cpu_ready}, 32'd1);
    check("cpu_rdata", cpu_rdata, exp_rd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int maxa;
    for (int i = 0; i < 19200; i++) mem[i] = (i < 9600) ? pat(i) : 32'd0;
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    vid_frame_start = 1'b0; vid_line_start = 1'b0; vid_line = '0; swap_req = 1'b0;
    repeat (3) cyc();
    smp();
    check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_vid_valid", {31'd0, vid_valid}, 32'd0);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_front_sel", {31'd0, front_sel}, 32'd0);
    check("rst_swap_pending", {31'd0, swap_pending}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    cyc();
    reset = 1'b0;

    // Line 0 from buffer 0
    run_line(0, 0);

    // CPU write then read back, back buffer is 1
    cpu_idle(5, 32'hDEAD_BEEF, 4'b0011, 9605, 32'd0);
    cpu_idle(5, 32'd0, 4'b0000, 9605, 32'h0000_BEEF);
    cyc();
    smp();
    check("cpu_ready_drop", {31'd0, cpu_ready}, 32'd0);

    // Line 239 with a CPU request waiting throughout
    cyc();
    vid_line_start = 1'b1;
    vid_line = 8'd239;
    push_line(239, 0, 39);
    smp();
    maxa = 0;
    for (int k = 1; k <= 41; k++) begin
      cyc();
      if (k == 1) begin
        vid_line_start = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 14'd100; cpu_wdata = 32'h1234_5678; cpu_wstrb = 4'hF;
      end
      if (k == 10) cpu_valid = 1'b0;
      smp();
      if (k == 9) begin
        check("slot_addr", {17'd0, mem_addr}, 32'd9700);
        check("slot_wstrb", {28'd0, mem_wstrb}, 32'hF);
      end else begin
        check("l239_addr", {17'd0, mem_addr}, 32'(9560 + ((k <= 8) ? k - 1 : k - 2)));
        if (int'(mem_addr) > maxa) maxa = int'(mem_addr);
      end
      if (k == 10) check("slot_ready", {31'd0, cpu_ready}, 32'd1);
    end
    check("max_addr", 32'(maxa), 32'd9599);
    cyc();
    smp();
    check("l239_state", {31'd0, dbg_state}, {31'd0, IDLE});

    // Line 2 aborted by line 3 while idx 20 is issued
    cyc();
    vid_line_start = 1'b1;
    vid_line = 8'd2;
    push_line(2, 0, 20);
    push_line(3, 0, 39);
    smp();
    for (int k = 1; k <= 21; k++) begin
      cyc();
      if (k == 1) vid_line_start = 1'b0;
      if (k == 21) begin vid_line_start = 1'b1; vid_line = 8'd3; end
      smp();
      check("l2_addr", {17'd0, mem_addr}, 32'(80 + k - 1));
    end
    cyc();
    vid_line_start = 1'b0;
    smp();
    check("restart_pulse", {31'd0, vid_restart}, 32'd1);
    check("restart_addr", {17'd0, mem_addr}, 32'd120);
    for (int i = 1; i < 40; i++) begin
      cyc();
      smp();
      if (i == 1) check("restart_clear", {31'd0, vid_restart}, 32'd0);
      check("l3_addr", {17'd0, mem_addr}, 32'(120 + i));
    end
    cyc();
    smp();
    check("l3_state", {31'd0, dbg_state}, {31'd0, IDLE});

    // Out-of-range CPU read during a fetch at the slot boundary: video not stalled
    cyc();
    vid_line_start = 1'b1;
    vid_line = 8'd10;
    push_line(10, 0, 39);
    smp();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (k == 1) vid_line_start = 1'b0;
      if (k == 9) begin cpu_valid = 1'b1; cpu_addr = 14'd9600; cpu_wstrb = 4'd0; cpu_wdata = 32'hFFFF_FFFF; end
      if (k == 10) cpu_valid = 1'b0;
      smp();
      check("l10_addr", {17'd0, mem_addr}, 32'(400 + k - 1));
      if (k == 9) check("oor_wstrb", {28'd0, mem_wstrb}, 32'd0);
      if (k == 10) begin
        check("oor_ready", {31'd0, cpu_ready}, 32'd1);
        check("oor_rdata", cpu_rdata, 32'd0);
      end
    end
    cyc();
    smp();
    check("l10_state", {31'd0, dbg_state}, {31'd0, IDLE});

    // Out-of-range CPU read while idle
    cpu_idle(9600, 32'hFFFF_FFFF, 4'b0000, 0, 32'd0);

    // line 240 is ignored
    cyc();
    vid_line_start = 1'b1;
    vid_line = 8'd240;
    smp();
    cyc();
    vid_line_start = 1'b0;
    smp();
    check("l240_state", {31'd0, dbg_state}, {31'd0, IDLE});
    check("l240_addr", {17'd0, mem_addr}, 32'd0);
    cyc();
    smp();
    check("l240_valid", {31'd0, vid_valid}, 32'd0);

    // Swap armed 10 cycles before frame start, with a redundant second request
    cyc();
    swap_req = 1'b1;
    smp();
    check("swap_not_yet", {31'd0, swap_pending}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      swap_req = (k == 5);
      vid_frame_start = (k == 10);
      smp();
      check("swap_pending", {31'd0, swap_pending}, 32'd1);
      check("front_hold", {31'd0, front_sel}, 32'd0);
    end
    cyc();
    vid_frame_start = 1'b0;
    smp();
    check("front_swapped", {31'd0, front_sel}, 32'd1);
    check("swap_cleared", {31'd0, swap_pending}, 32'd0);
    cpu_idle(0, 32'hCAFE_F00D, 4'hF, 0, 32'd0);
    run_line(0, 1);

    // swap_req coincident with frame start
    cyc();
    swap_req = 1'b1;
    vid_frame_start = 1'b1;
    smp();
    cyc();
    swap_req = 1'b0;
    vid_frame_start = 1'b0;
    smp();
    check("same_cycle_front", {31'd0, front_sel}, 32'd0);
    check("same_cycle_pending", {31'd0, swap_pending}, 32'd0);

    repeat (3) cyc();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
